// File: rtl/spmmio_xbar_pkg.sv
// rtl/spmmio_xbar_pkg.sv - shared types and constants for the MMIO crossbar
package spmmio_xbar_pkg;

    localparam int TIMER_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } state_t;

endpackage

// File: rtl/spmmio_xbar_timer.sv
// rtl/spmmio_xbar_timer.sv - busy-cycle timer flagging the last allowed cycle before a bus error
module spmmio_xbar_timer
    import spmmio_xbar_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + TIMER_W'(1);
        end
    end

    assign expire = enable && (count == TIMER_W'(TIMEOUT - 1));

endmodule

// File: rtl/spmmio_xbar.sv
// rtl/spmmio_xbar.sv - Wishbone-style MMIO decoder with registered responses and bus-error timeout
// Optional error logging (err_count/err_adr) enabled by defining SPMMIO_XBAR_ERRLOG_EN.
module spmmio_xbar
    import spmmio_xbar_pkg::*;
#(
    parameter int                    NUM_SLAVES = 8,
    parameter int                    DEC_BITS   = 8,
    parameter logic [NUM_SLAVES-1:0] ACK_MASK   = '0,
    parameter int                    TIMEOUT    = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [23:0]                adr_i,
    input  logic                       stb_i,
    input  logic                       cyc_i,
    input  logic [3:0]                 sel_i,
    input  logic                       we_i,
    input  logic [31:0]                dat_i,
    output logic                       ack_o,
    output logic                       err_o,
    output logic [31:0]                dat_o,
    output logic [NUM_SLAVES-1:0]      s_cs,
    input  logic [NUM_SLAVES-1:0]      s_ack,
    input  logic [32*NUM_SLAVES-1:0]   s_dat,
    output logic [15:0]                err_count,
    output logic [23:0]                err_adr
);

    localparam int SIDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    state_t              state;
    state_t              state_next;
    logic [SIDX_W-1:0]   sidx_q;
    logic [DEC_BITS-1:0] req_idx;
    logic                req;
    logic                mapped;
    logic [NUM_SLAVES-1:0] onehot;
    logic                handshake;
    logic                slave_ack;
    logic                expire;
    logic [31:0]         rd_mux;

    // Write-side signals go straight to the slaves on the shared bus.
    logic unused_ok;
    assign unused_ok = &{1'b0, sel_i, we_i, dat_i, adr_i};

    assign req     = cyc_i & stb_i;
    assign req_idx = adr_i[24-DEC_BITS +: DEC_BITS];
    assign mapped  = 32'(req_idx) < 32'(NUM_SLAVES);

    always_comb begin
        onehot         = '0;
        onehot[sidx_q] = 1'b1;
    end

    assign handshake = |(onehot & ACK_MASK);
    assign slave_ack = |(onehot & ACK_MASK & s_ack);

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (onehot[i]) begin
                rd_mux = rd_mux | s_dat[32*i +: 32];
            end
        end
    end

    spmmio_xbar_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state != BUSY),
        .enable (state == BUSY),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort beats termination; a late ack on the expiry cycle still beats the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    state_next = mapped ? BUSY : ERR;
                end
            end
            BUSY: begin
                if (!req) begin
                    state_next = IDLE;
                end else if (!handshake || slave_ack) begin
                    state_next = RESP;
                end else if (expire) begin
                    state_next = ERR;
                end
            end
            RESP:    state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ack_o = (state == RESP);
        err_o = (state == ERR);
        s_cs  = (state == BUSY) ? onehot : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sidx_q <= '0;
            dat_o  <= '0;
        end else begin
            if (state == IDLE && req && mapped) begin
                sidx_q <= SIDX_W'(req_idx);
            end
            if (state == BUSY && state_next == RESP) begin
                dat_o <= rd_mux;
            end
        end
    end

`ifdef SPMMIO_XBAR_ERRLOG_EN
    logic [23:0] adr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            adr_q     <= '0;
            err_count <= '0;
            err_adr   <= '0;
        end else begin
            if (state == IDLE && req) begin
                adr_q <= adr_i;
            end
            // Unmapped errors come straight from IDLE, before adr_q is loaded.
            if (state_next == ERR) begin
                err_adr <= (state == IDLE) ? adr_i : adr_q;
                if (err_count != 16'hFFFF) begin
                    err_count <= err_count + 16'd1;
                end
            end
        end
    end
`else
    assign err_count = '0;
    assign err_adr   = '0;
`endif

endmodule

// File: tb/tb_spmmio_xbar.sv
// tb/tb_spmmio_xbar.sv - table-driven directed test of spmmio_xbar
module tb_spmmio_xbar;

    logic         clk = 1'b0;
    logic         reset;
    logic [23:0]  adr_i;
    logic         stb_i;
    logic         cyc_i;
    logic [3:0]   sel_i;
    logic         we_i;
    logic [31:0]  dat_i;
    logic         ack_o;
    logic         err_o;
    logic [31:0]  dat_o;
    logic [7:0]   s_cs;
    logic [7:0]   s_ack;
    logic [255:0] s_dat;
    logic [15:0]  err_count;
    logic [23:0]  err_adr;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    logic [23:0] exp_eadr = '0;

    always #5 clk = ~clk;

    spmmio_xbar #(
        .NUM_SLAVES (8),
        .DEC_BITS   (8),
        .ACK_MASK   (8'b0000_1000),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .adr_i     (adr_i),
        .stb_i     (stb_i),
        .cyc_i     (cyc_i),
        .sel_i     (sel_i),
        .we_i      (we_i),
        .dat_i     (dat_i),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .dat_o     (dat_o),
        .s_cs      (s_cs),
        .s_ack     (s_ack),
        .s_dat     (s_dat),
        .err_count (err_count),
        .err_adr   (err_adr)
    );

    typedef struct {
        logic [23:0] adr;
        logic        we;
        int          ack_delay;
        logic [31:0] rdat;
        int          exp_cs_cnt;
        logic [7:0]  exp_cs;
        int          exp_ack_cyc;
        int          exp_err_cyc;
        logic        chk_dat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic load_sdat(input logic [23:0] adr, input logic [31:0] rdat);
        for (int i = 0; i < 8; i++) s_dat[32*i +: 32] = 32'h0BAD0000 | 32'(i);
        if (adr[23:16] < 8'd8) s_dat[32*adr[18:16] +: 32] = rdat;
    endtask

    // Starts at posedge+1 (cycle 0); responds with s_ack on the (ack_delay+1)-th cs cycle.
    task automatic run_txn(input logic [23:0] adr, input logic we, input int ack_delay,
                           output int cs_cnt, output logic [7:0] cs_or, output int ack_cyc,
                           output int err_cyc, output logic [31:0] dat_seen, output int viol);
        cs_cnt = 0; cs_or = '0; ack_cyc = -1; err_cyc = -1; dat_seen = '0; viol = 0;
        adr_i = adr; we_i = we; cyc_i = 1'b1; stb_i = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (s_cs != 8'h00) begin
                cs_cnt++;
                cs_or |= s_cs;
                if ($countones(s_cs) != 1) viol++;
            end
            if (ack_o && err_o) viol++;
            if ((ack_o || err_o) && s_cs != 8'h00) viol++;
            if (ack_o || err_o) begin
                if (ack_o) begin
                    ack_cyc  = k;
                    dat_seen = dat_o;
                end else begin
                    err_cyc = k;
                end
                break;
            end
            if (ack_delay >= 0 && s_cs != 8'h00 && cs_cnt == ack_delay + 1) s_ack = s_cs;
            else s_ack = '0;
        end
        cyc_i = 1'b0; stb_i = 1'b0; s_ack = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cs_cnt, ack_cyc, err_cyc, viol, flag;
        logic [7:0]  cs_or;
        logic [31:0] dat_seen;

        vecs[0] = '{24'h020004, 1'b0, -1, 32'hDEADBEEF, 1, 8'h04, 2, -1, 1'b1};
        vecs[1] = '{24'h030000, 1'b1,  5, 32'h12345678, 6, 8'h08, 7, -1, 1'b0};
        vecs[2] = '{24'h0A0000, 1'b0, -1, 32'h0,        0, 8'h00, -1, 1, 1'b0};
        vecs[3] = '{24'h030010, 1'b0, -1, 32'h0,       16, 8'h08, -1, 17, 1'b0};
        vecs[4] = '{24'h030020, 1'b0, 15, 32'hA1B2C3D4,16, 8'h08, 17, -1, 1'b1};
        vecs[5] = '{24'h000000, 1'b0, -1, 32'hCAFEF00D, 1, 8'h01, 2, -1, 1'b1};
        vecs[6] = '{24'h07FFFF, 1'b0, -1, 32'h77777777, 1, 8'h80, 2, -1, 1'b1};
        vecs[7] = '{24'hFF0000, 1'b0, -1, 32'h0,        0, 8'h00, -1, 1, 1'b0};
        vecs[8] = '{24'h080000, 1'b0, -1, 32'h0,        0, 8'h00, -1, 1, 1'b0};
        vecs[9] = '{24'h030000, 1'b0,  0, 32'h5A5A0003, 1, 8'h08, 2, -1, 1'b1};

        reset = 1'b1; adr_i = '0; stb_i = 0; cyc_i = 0; sel_i = 4'hF; we_i = 0;
        dat_i = 32'h01020304; s_ack = '0; s_dat = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 64'(s_cs), 64'(0));
        check("rst_ack", 64'(ack_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_dat", 64'(dat_o), 64'(0));
        check("rst_ecnt", 64'(err_count), 64'(0));
        check("rst_eadr", 64'(err_adr), 64'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            load_sdat(vecs[i].adr, vecs[i].rdat);
            run_txn(vecs[i].adr, vecs[i].we, vecs[i].ack_delay,
                    cs_cnt, cs_or, ack_cyc, err_cyc, dat_seen, viol);
            check($sformatf("v%0d_cs_cnt", i), 64'(cs_cnt), 64'(vecs[i].exp_cs_cnt));
            check($sformatf("v%0d_cs_sel", i), 64'(cs_or), 64'(vecs[i].exp_cs));
            check($sformatf("v%0d_ack_cyc", i), 64'(ack_cyc), 64'(vecs[i].exp_ack_cyc));
            check($sformatf("v%0d_err_cyc", i), 64'(err_cyc), 64'(vecs[i].exp_err_cyc));
            check($sformatf("v%0d_overlap", i), 64'(viol), 64'(0));
            if (vecs[i].chk_dat)
                check($sformatf("v%0d_dat", i), 64'(dat_seen), 64'(vecs[i].rdat));
`ifdef SPMMIO_XBAR_ERRLOG_EN
            if (vecs[i].exp_err_cyc > 0) begin
                exp_cnt++;
                exp_eadr = vecs[i].adr;
            end
`endif
            check($sformatf("v%0d_ecnt", i), 64'(err_count), 64'(exp_cnt));
            check($sformatf("v%0d_eadr", i), 64'(err_adr), 64'(exp_eadr));
        end

        // Master abort on the third BUSY cycle of a handshaked access.
        load_sdat(24'h030000, 32'h0);
        adr_i = 24'h030000; cyc_i = 1; stb_i = 1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_cs_c3", 64'(s_cs), 64'(8'h08));
        cyc_i = 0; stb_i = 0;
        flag = 0;
        for (int k = 4; k <= 9; k++) begin
            @(posedge clk); #1;
            if (s_cs != 8'h00 || ack_o || err_o) flag++;
        end
        check("abort_quiet", 64'(flag), 64'(0));
        check("abort_ecnt", 64'(err_count), 64'(exp_cnt));
        load_sdat(24'h020000, 32'h13579BDF);
        run_txn(24'h020000, 1'b0, -1, cs_cnt, cs_or, ack_cyc, err_cyc, dat_seen, viol);
        check("post_abort_ack", 64'(ack_cyc), 64'(2));
        check("post_abort_dat", 64'(dat_seen), 64'(32'h13579BDF));

        // Reset while BUSY.
        adr_i = 24'h030000; cyc_i = 1; stb_i = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("brst_cs", 64'(s_cs), 64'(0));
        check("brst_ack", 64'(ack_o), 64'(0));
        check("brst_err", 64'(err_o), 64'(0));
        check("brst_dat", 64'(dat_o), 64'(0));
        check("brst_ecnt", 64'(err_count), 64'(0));
        check("brst_eadr", 64'(err_adr), 64'(0));
        exp_cnt = 0; exp_eadr = '0;
        reset = 1'b0; cyc_i = 0; stb_i = 0;
        @(posedge clk); #1;
        load_sdat(24'h000000, 32'h600DF00D);
        run_txn(24'h000000, 1'b0, -1, cs_cnt, cs_or, ack_cyc, err_cyc, dat_seen, viol);
        check("post_rst_cs", 64'(cs_or), 64'(8'h01));
        check("post_rst_ack", 64'(ack_cyc), 64'(2));
        check("post_rst_err", 64'(err_cyc), 64'(-1));
        check("post_rst_dat", 64'(dat_seen), 64'(32'h600DF00D));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
